bomb_scheduler: RTL and testbench

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

---
 rtl/bomb_pkg.sv | 32 +++
 rtl/bomb_slot.sv | 98 +++++++++
 rtl/bomb_scheduler.sv | 155 +++++++++++++++
 tb/tb_bomb_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared slot-state enum, stats layout and sizing constants for the bomb scheduler
package bomb_pkg;

  localparam int NUM_SLOTS  = 6;
  localparam int FUSE_TICKS = 2;
  localparam int GRID_MAX   = 10;

  // Even slots belong to P1, odd slots to P2.
  localparam logic [NUM_SLOTS-1:0] P1_MASK = 6'b010101;
  localparam logic [NUM_SLOTS-1:0] P2_MASK = 6'b101010;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_FUSE     = 2'd1,
    SLOT_BLAST    = 2'd2,
    SLOT_DETONATE = 2'd3
  } slot_state_e;

  typedef struct packed {
    logic [1:0] radius;
    logic [1:0] potency;
  } bomb_stats_t;

  function automatic logic coord_ok(input logic [3:0] tx, input logic [3:0] ty);
    return (tx <= 4'(GRID_MAX)) && (ty <= 4'(GRID_MAX));
  endfunction

  function automatic logic [NUM_SLOTS-1:0] lowest_set(input logic [NUM_SLOTS-1:0] v);
    return v & (~v + NUM_SLOTS'(1));
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// rtl/bomb_slot.sv - one bomb slot: IDLE -> FUSE -> BLAST -> DETONATE lifecycle with its tick counter
module bomb_slot
  import bomb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        tick_i,
  input  logic        load_i,
  input  logic [3:0]  tx_i,
  input  logic [3:0]  ty_i,
  input  bomb_stats_t stats_i,
  input  logic        det_done_i,
  output slot_state_e state_o,
  output logic [3:0]  tx_o,
  output logic [3:0]  ty_o,
  output logic [1:0]  radius_o,
  output logic        bomb_o,
  output logic        blast_o
);

  localparam logic [1:0] FUSE_LAST = 2'(FUSE_TICKS - 1);

  slot_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  tx_q, tx_d, ty_q, ty_d;
  bomb_stats_t stats_q, stats_d;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SLOT_IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      stats_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      stats_q <= stats_d;
    end
  end

  // A load is only honoured from IDLE, so a coincident tick never counts toward the new fuse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    stats_d = stats_q;
    if (clear_i) begin
      state_d = SLOT_IDLE;
      cnt_d   = '0;
      tx_d    = '0;
      ty_d    = '0;
      stats_d = '0;
    end else begin
      case (state_q)
        SLOT_IDLE: if (load_i) begin
          state_d = SLOT_FUSE;
          cnt_d   = '0;
          tx_d    = tx_i;
          ty_d    = ty_i;
          stats_d = stats_i;
        end
        SLOT_FUSE: if (tick_i) begin
          if (cnt_q == FUSE_LAST) begin
            state_d = SLOT_BLAST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        SLOT_BLAST: if (tick_i) begin
          if (cnt_q == stats_q.potency) begin
            state_d = SLOT_DETONATE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        SLOT_DETONATE: if (det_done_i) state_d = SLOT_IDLE;
        default: state_d = SLOT_IDLE;
      endcase
    end
  end

  always_comb begin
    state_o  = state_q;
    tx_o     = tx_q;
    ty_o     = ty_q;
    radius_o = stats_q.radius;
    bomb_o   = (state_q == SLOT_FUSE);
    blast_o  = (state_q == SLOT_BLAST);
  end

endmodule

// File: rtl/bomb_scheduler.sv
// rtl/bomb_scheduler.sv - placement arbitration and detonation mux over six bomb slots; BOMB_SCHED_RR_EN enables round-robin tie-break
module bomb_scheduler
  import bomb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  input  logic       place_p1,
  input  logic       place_p2,
  input  logic [3:0] tx_p1,
  input  logic [3:0] ty_p1,
  input  logic [3:0] tx_p2,
  input  logic [3:0] ty_p2,
  input  logic [3:0] stats_p1,
  input  logic [3:0] stats_p2,
  output logic       ack_p1,
  output logic       nack_p1,
  output logic       ack_p2,
  output logic       nack_p2,
  output logic [5:0] slot_bomb,
  output logic [5:0] slot_blast,
  output logic       det_valid,
  input  logic       det_ready,
  output logic [2:0] det_slot,
  output logic [3:0] det_tx,
  output logic [3:0] det_ty,
  output logic [1:0] det_radius
);

  slot_state_e          slot_state [NUM_SLOTS];
  logic [3:0]           slot_tx    [NUM_SLOTS];
  logic [3:0]           slot_ty    [NUM_SLOTS];
  logic [1:0]           slot_rad   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] load, det_done, idle, hit1, hit2, free1, free2;
  logic                 ok1, ok2, conflict, p1_wins, acc1, acc2;
  logic                 ack1_q, nack1_q, ack2_q, nack2_q;
  logic                 det_any, det_lock_q;
  logic [2:0]           det_low, det_sel, det_sel_q;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    localparam bit IS_P1 = (i % 2) == 0;
    bomb_slot u_slot (
      .clk       (clk),
      .rst_i     (reset),
      .clear_i   (clear),
      .tick_i    (tick),
      .load_i    (load[i]),
      .tx_i      (IS_P1 ? tx_p1 : tx_p2),
      .ty_i      (IS_P1 ? ty_p1 : ty_p2),
      .stats_i   (bomb_stats_t'(IS_P1 ? stats_p1 : stats_p2)),
      .det_done_i(det_done[i]),
      .state_o   (slot_state[i]),
      .tx_o      (slot_tx[i]),
      .ty_o      (slot_ty[i]),
      .radius_o  (slot_rad[i]),
      .bomb_o    (slot_bomb[i]),
      .blast_o   (slot_blast[i])
    );
  end

  always_comb begin
    idle = '0;
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idle[i] = (slot_state[i] == SLOT_IDLE);
      hit1[i] = !idle[i] && (slot_tx[i] == tx_p1) && (slot_ty[i] == ty_p1);
      hit2[i] = !idle[i] && (slot_tx[i] == tx_p2) && (slot_ty[i] == ty_p2);
    end
  end

`ifdef BOMB_SCHED_RR_EN
  logic rr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         rr_q <= 1'b0;
    else if (clear)    rr_q <= 1'b0;
    else if (conflict) rr_q <= ~rr_q;
  end
  assign p1_wins = ~rr_q;
`else
  assign p1_wins = 1'b1;
`endif

  // A same-tile conflict only exists when both requests would otherwise be accepted.
  always_comb begin
    free1    = idle & P1_MASK;
    free2    = idle & P2_MASK;
    ok1      = place_p1 && coord_ok(tx_p1, ty_p1) && (|free1) && !(|hit1);
    ok2      = place_p2 && coord_ok(tx_p2, ty_p2) && (|free2) && !(|hit2);
    conflict = ok1 && ok2 && (tx_p1 == tx_p2) && (ty_p1 == ty_p2);
    acc1     = ok1 && (!conflict || p1_wins);
    acc2     = ok2 && (!conflict || !p1_wins);
    load     = '0;
    if (!clear)
      load = ({NUM_SLOTS{acc1}} & lowest_set(free1)) | ({NUM_SLOTS{acc2}} & lowest_set(free2));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack1_q  <= 1'b0;
      nack1_q <= 1'b0;
      ack2_q  <= 1'b0;
      nack2_q <= 1'b0;
    end else if (clear) begin
      ack1_q  <= 1'b0;
      nack1_q <= 1'b0;
      ack2_q  <= 1'b0;
      nack2_q <= 1'b0;
    end else begin
      ack1_q  <= acc1;
      nack1_q <= place_p1 && !acc1;
      ack2_q  <= acc2;
      nack2_q <= place_p2 && !acc2;
    end
  end

  assign ack_p1  = ack1_q;
  assign nack_p1 = nack1_q;
  assign ack_p2  = ack2_q;
  assign nack_p2 = nack2_q;

  // Once presented and stalled, the chosen slot is latched so a lower slot entering DETONATE cannot preempt it.
  always_comb begin
    det_any = 1'b0;
    det_low = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_state[i] == SLOT_DETONATE) begin
        det_any = 1'b1;
        det_low = 3'(i);
      end
    end
    det_sel    = det_lock_q ? det_sel_q : det_low;
    det_valid  = det_any;
    det_slot   = det_any ? det_sel : '0;
    det_tx     = det_any ? slot_tx[det_sel] : '0;
    det_ty     = det_any ? slot_ty[det_sel] : '0;
    det_radius = det_any ? slot_rad[det_sel] : '0;
    det_done   = (det_any && det_ready) ? (NUM_SLOTS'(1) << det_sel) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_lock_q <= 1'b0;
      det_sel_q  <= '0;
    end else if (clear) begin
      det_lock_q <= 1'b0;
      det_sel_q  <= '0;
    end else begin
      det_lock_q <= det_any && !det_ready;
      det_sel_q  <= det_sel;
    end
  end

endmodule

// File: tb/tb_bomb_scheduler.sv
// tb/tb_bomb_scheduler.sv - directed and randomized checks of bomb_scheduler against a countdown reference model
module tb_bomb_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1, clear = 1'b0, tick = 1'b0;
  logic       place_p1 = 1'b0, place_p2 = 1'b0;
  logic [3:0] tx_p1 = '0, ty_p1 = '0, tx_p2 = '0, ty_p2 = '0;
  logic [3:0] stats_p1 = '0, stats_p2 = '0;
  logic       det_ready = 1'b0;
  logic       ack_p1, nack_p1, ack_p2, nack_p2, det_valid;
  logic [5:0] slot_bomb, slot_blast;
  logic [2:0] det_slot;
  logic [3:0] det_tx, det_ty;
  logic [1:0] det_radius;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bomb_scheduler dut (
    .clk(clk), .reset(reset), .clear(clear), .tick(tick),
    .place_p1(place_p1), .place_p2(place_p2),
    .tx_p1(tx_p1), .ty_p1(ty_p1), .tx_p2(tx_p2), .ty_p2(ty_p2),
    .stats_p1(stats_p1), .stats_p2(stats_p2),
    .ack_p1(ack_p1), .nack_p1(nack_p1), .ack_p2(ack_p2), .nack_p2(nack_p2),
    .slot_bomb(slot_bomb), .slot_blast(slot_blast),
    .det_valid(det_valid), .det_ready(det_ready), .det_slot(det_slot),
    .det_tx(det_tx), .det_ty(det_ty), .det_radius(det_radius)
  );

  // Model: stage 0 free, 1 fuse, 2 blast, 3 waiting to detonate; left = ticks remaining in stage.
  int m_stg[6], m_left[6], m_tx[6], m_ty[6], m_rad[6], m_pot[6];
  int m_pres;
  bit m_rr;
  bit e_ack1, e_nack1, e_ack2, e_nack2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_stg[i] = 0; m_left[i] = 0; m_tx[i] = 0; m_ty[i] = 0; m_rad[i] = 0; m_pot[i] = 0;
    end
    m_pres = -1; m_rr = 0;
    e_ack1 = 0; e_nack1 = 0; e_ack2 = 0; e_nack2 = 0;
  endtask

  function automatic int free_slot(input int owner);
    for (int k = 0; k < 3; k++) if (m_stg[2*k+owner] == 0) return 2*k + owner;
    return -1;
  endfunction

  function automatic bit tile_busy(input int x, input int y);
    for (int i = 0; i < 6; i++) if (m_stg[i] != 0 && m_tx[i] == x && m_ty[i] == y) return 1;
    return 0;
  endfunction

  task automatic model_edge();
    bit ok1, ok2, a1, a2;
    int f1, f2;
    if (clear) begin
      model_reset();
      return;
    end
    f1  = free_slot(0);
    f2  = free_slot(1);
    ok1 = place_p1 && tx_p1 <= 10 && ty_p1 <= 10 && f1 >= 0 && !tile_busy(int'(tx_p1), int'(ty_p1));
    ok2 = place_p2 && tx_p2 <= 10 && ty_p2 <= 10 && f2 >= 0 && !tile_busy(int'(tx_p2), int'(ty_p2));
    a1 = ok1; a2 = ok2;
    if (ok1 && ok2 && tx_p1 == tx_p2 && ty_p1 == ty_p2) begin
`ifdef BOMB_SCHED_RR_EN
      a1 = !m_rr; a2 = m_rr; m_rr = !m_rr;
`else
      a2 = 0;
`endif
    end
    if (m_pres >= 0 && det_ready) m_stg[m_pres] = 0;
    if (tick) begin
      for (int i = 0; i < 6; i++) begin
        if (m_stg[i] == 1) begin
          m_left[i]--;
          if (m_left[i] == 0) begin m_stg[i] = 2; m_left[i] = m_pot[i] + 1; end
        end else if (m_stg[i] == 2) begin
          m_left[i]--;
          if (m_left[i] == 0) m_stg[i] = 3;
        end
      end
    end
    if (a1) begin
      m_stg[f1] = 1; m_left[f1] = 2; m_tx[f1] = tx_p1; m_ty[f1] = ty_p1;
      m_rad[f1] = stats_p1[3:2]; m_pot[f1] = stats_p1[1:0];
    end
    if (a2) begin
      m_stg[f2] = 1; m_left[f2] = 2; m_tx[f2] = tx_p2; m_ty[f2] = ty_p2;
      m_rad[f2] = stats_p2[3:2]; m_pot[f2] = stats_p2[1:0];
    end
    e_ack1 = a1; e_nack1 = place_p1 && !a1;
    e_ack2 = a2; e_nack2 = place_p2 && !a2;
    if (!(m_pres >= 0 && m_stg[m_pres] == 3)) begin
      m_pres = -1;
      for (int i = 5; i >= 0; i--) if (m_stg[i] == 3) m_pres = i;
    end
  endtask

  task automatic compare_all();
    logic [5:0] eb, el;
    for (int i = 0; i < 6; i++) begin
      eb[i] = (m_stg[i] == 1);
      el[i] = (m_stg[i] == 2);
    end
    chk("ack_p1", ack_p1, e_ack1);
    chk("nack_p1", nack_p1, e_nack1);
    chk("ack_p2", ack_p2, e_ack2);
    chk("nack_p2", nack_p2, e_nack2);
    chk("slot_bomb", slot_bomb, eb);
    chk("slot_blast", slot_blast, el);
    chk("det_valid", det_valid, m_pres >= 0);
    chk("det_slot", det_slot, m_pres >= 0 ? m_pres : 0);
    chk("det_tx", det_tx, m_pres >= 0 ? m_tx[m_pres] : 0);
    chk("det_ty", det_ty, m_pres >= 0 ? m_ty[m_pres] : 0);
    chk("det_radius", det_radius, m_pres >= 0 ? m_rad[m_pres] : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    place_p1 = 0; place_p2 = 0; tick = 0; clear = 0;
  endtask

  task automatic pl(input int who, input int x, input int y, input int s);
    if (who == 1) begin place_p1 = 1; tx_p1 = 4'(x); ty_p1 = 4'(y); stats_p1 = 4'(s); end
    else          begin place_p2 = 1; tx_p2 = 4'(x); ty_p2 = 4'(y); stats_p2 = 4'(s); end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1; step(); step();
    end
  endtask

  task automatic drain();
    det_ready = 1; ticks(12); det_ready = 0;
  endtask

  logic [2:0] won;
  logic [2:0] won_exp;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bomb", slot_bomb, 0);
    chk("reset_det_valid", det_valid, 0);
    chk("reset_ack", {ack_p1, nack_p1, ack_p2, nack_p2}, 0);
    reset = 0;

    // single bomb life cycle
    pl(1, 3, 4, 4'b1001); step();
    chk("r030_ack", ack_p1, 1);
    chk("r030_fuse0", slot_bomb[0], 1);
    ticks(1); chk("r030_fuse1", slot_bomb[0], 1);
    ticks(1); chk("r030_blast0", slot_blast[0], 1);
    ticks(1); chk("r030_blast1", slot_blast[0], 1);
    ticks(1);
    chk("r030_det", {det_valid, det_slot, det_tx, det_ty}, {1'b1, 3'd0, 4'd3, 4'd4});
    det_ready = 1; step(); det_ready = 0;
    chk("r030_done", det_valid, 0);

    // slot exhaustion and reuse
    pl(1, 1, 1, 0); step();
    pl(1, 2, 2, 0); step();
    pl(1, 3, 3, 0); step();
    chk("r031_three", slot_bomb, 6'b010101);
    pl(1, 4, 4, 0); step();
    chk("r031_nack", nack_p1, 1);
    ticks(3);
    chk("r031_det0", det_slot, 0);
    det_ready = 1; step(); det_ready = 0;
    chk("r031_next", det_slot, 2);
    pl(1, 6, 6, 0); step();
    chk("r031_reuse", slot_bomb[0], 1);
    drain();

    // stalled detonation holds the presented slot
    pl(1, 7, 7, 0); pl(2, 8, 8, 0); step();
    ticks(3);
    for (int k = 0; k < 10; k++) begin
      step(); chk("r033_hold", det_slot, 0);
    end
    det_ready = 1; step(); det_ready = 0;
    chk("r033_next", {det_valid, det_slot}, {1'b1, 3'd1});
    drain();

    // same-tile conflict resolution
    for (int r = 0; r < 3; r++) begin
      pl(1, 5, 5, 0); pl(2, 5, 5, 0); step();
      won[r] = ack_p1;
      chk("r032_one_wins", {ack_p1, ack_p2}, ack_p1 ? 2'b10 : 2'b01);
      drain();
    end
`ifdef BOMB_SCHED_RR_EN
    won_exp = 3'b101;
`else
    won_exp = 3'b111;
`endif
    chk("r032_winners", won, won_exp);

    // out-of-range coordinate and placement coincident with tick
    pl(1, 11, 2, 0); step();
    chk("r035_nack", {nack_p1, slot_bomb}, {1'b1, 6'b0});
    pl(1, 2, 2, 0); tick = 1; step();
    chk("r035_fuse0", slot_bomb[0], 1);
    ticks(1); chk("r035_fuse1", slot_bomb[0], 1);
    ticks(1); chk("r035_blast", slot_blast[0], 1);
    drain();

    // asynchronous reset mid-handshake
    pl(1, 9, 9, 0); step();
    ticks(3);
    pl(1, 10, 10, 4'b0011); step();
    ticks(2);
    chk("r034_pre", {slot_blast[2], det_valid}, 2'b11);
    #2 reset = 1;
    #1;
    chk("r034_async", {det_valid, det_slot, det_tx, det_ty, det_radius, slot_bomb, slot_blast},
        '0);
    chk("r034_acks", {ack_p1, nack_p1, ack_p2, nack_p2}, 0);
    model_reset();
    @(posedge clk); #1 reset = 0;
    pl(1, 10, 10, 0); step();
    chk("r034_replace", ack_p1, 1);
    drain();

    // clear beats a coincident placement
    pl(1, 1, 2, 0); clear = 1; step();
    chk("r025_silent", {ack_p1, nack_p1}, 0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      place_p1 = ($urandom % 3) == 0;
      place_p2 = ($urandom % 3) == 0;
      tx_p1 = ($urandom % 10 == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 3));
      ty_p1 = 4'($urandom_range(0, 3));
      tx_p2 = ($urandom % 10 == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 3));
      ty_p2 = 4'($urandom_range(0, 3));
      stats_p1 = 4'($urandom);
      stats_p2 = 4'($urandom);
      tick = ($urandom % 4) == 0;
      det_ready = $urandom % 2;
      clear = ($urandom % 150) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
